// File: rtl/cordic_exp_sched_if.sv
// Requester-side bundle of the exp() scheduler: operand handshake plus
// the per-requester result strobe.
interface cordic_exp_sched_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport master (
    output req_valid, req_data,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/cordic_exp_sched.sv
// Round-robin scheduler sharing one fixed-latency exp() core among several
// requesters; a tag pipe running beside the core routes each result home.
module cordic_exp_sched #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REQ      = 4,
  parameter int REQ_W        = 2,
  parameter int PIPE_LATENCY = 13,
  parameter int WARMUP       = 16
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         cfg_enable,
  cordic_exp_sched_if.slave            req,
  output logic signed [DATA_WIDTH-1:0] core_x,
  input  logic signed [DATA_WIDTH-1:0] core_rho,
  output logic                         busy,
  output logic [1:0]                   state_o,
  output logic [31:0]                  issue_cnt
);

  localparam int CNT_W  = $clog2(PIPE_LATENCY + 2) + 1;
  localparam int WARM_W = $clog2(WARMUP + 1);

  typedef enum logic [1:0] {
    ST_WARM  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [REQ_W-1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  function automatic logic [REQ_W-1:0] next_ptr(input logic [REQ_W-1:0] id);
    return (id == REQ_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  state_t                        state_q, state_d;
  logic [WARM_W-1:0]             warm_cnt_q;
  logic [REQ_W-1:0]              rr_ptr_q;
  logic [CNT_W-1:0]              inflight_q;
  logic [31:0]                   issue_cnt_q;

  logic                          grant_hit;
  logic [REQ_W-1:0]              grant_id;
  logic [REQ_W-1:0]              scan_idx;
  logic [NUM_REQ-1:0]            grant;

  logic signed [DATA_WIDTH-1:0]  core_x_p0;
  logic                          tag_vld_p [0:PIPE_LATENCY];
  logic [REQ_W-1:0]              tag_id_p  [0:PIPE_LATENCY];
  logic [NUM_REQ-1:0]            rsp_vld_p2;
  logic signed [DATA_WIDTH-1:0]  rsp_data_p2;

  // Round-robin search starting at rr_ptr; only RUN with enable high may grant.
  always_comb begin
    grant_hit = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    if (state_q == ST_RUN && cfg_enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = REQ_W'((int'(rr_ptr_q) + k) % NUM_REQ);
        if (!grant_hit && req.req_valid[scan_idx]) begin
          grant_hit = 1'b1;
          grant_id  = scan_idx;
        end
      end
    end
    grant = grant_hit ? onehot(grant_id) : '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WARM:  if (warm_cnt_q == WARM_W'(WARMUP - 1))
                  state_d = cfg_enable ? ST_RUN : ST_HALT;
      ST_RUN:   if (!cfg_enable) state_d = ST_DRAIN;
      ST_DRAIN: if (inflight_q == '0) state_d = ST_HALT;
      ST_HALT:  if (cfg_enable) state_d = ST_RUN;
      default:  state_d = ST_WARM;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_WARM;
      warm_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      inflight_q  <= '0;
      issue_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_WARM) warm_cnt_q <= warm_cnt_q + 1'b1;
      if (grant_hit) begin
        rr_ptr_q    <= next_ptr(grant_id);
        issue_cnt_q <= issue_cnt_q + 32'd1;
      end
      case ({grant_hit, tag_vld_p[PIPE_LATENCY]})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // p0: operand to the core, tag enters the shift register alongside it
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      core_x_p0 <= '0;
      for (int s = 0; s <= PIPE_LATENCY; s++) begin
        tag_vld_p[s] <= 1'b0;
        tag_id_p[s]  <= '0;
      end
    end else begin
      if (grant_hit) core_x_p0 <= req.req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
      tag_vld_p[0] <= grant_hit;
      tag_id_p[0]  <= grant_id;
      for (int s = 1; s <= PIPE_LATENCY; s++) begin
        tag_vld_p[s] <= tag_vld_p[s-1];
        tag_id_p[s]  <= tag_id_p[s-1];
      end
    end
  end

  // p2: last tap lines up with core_rho; capture and strobe the owner
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rsp_vld_p2  <= '0;
      rsp_data_p2 <= '0;
    end else begin
      rsp_vld_p2 <= tag_vld_p[PIPE_LATENCY] ? onehot(tag_id_p[PIPE_LATENCY]) : '0;
      if (tag_vld_p[PIPE_LATENCY]) rsp_data_p2 <= core_rho;
    end
  end

  assign req.req_ready = grant;
  assign req.rsp_valid = rsp_vld_p2;
  assign req.rsp_data  = rsp_data_p2;
  assign core_x        = core_x_p0;
  assign busy          = (inflight_q != '0);
  assign state_o       = state_q;
  assign issue_cnt     = issue_cnt_q;

endmodule

// File: tb/tb_cordic_exp_sched.sv
// Scoreboard bench for cordic_exp_sched driving a behavioural Q16.16 exp core.
module tb_cordic_exp_sched;
  localparam int DW   = 32;
  localparam int NREQ = 4;
  localparam int RW   = 2;
  localparam int LAT  = 13;
  localparam int WARM = 16;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic cfg_enable = 1'b1;
  logic signed [DW-1:0] core_x, core_rho;
  logic busy;
  logic [1:0] state_o;
  logic [31:0] issue_cnt;

  cordic_exp_sched_if #(.DATA_WIDTH(DW), .NUM_REQ(NREQ)) bus ();

  cordic_exp_sched #(
    .DATA_WIDTH(DW), .NUM_REQ(NREQ), .REQ_W(RW), .PIPE_LATENCY(LAT), .WARMUP(WARM)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_enable(cfg_enable), .req(bus),
    .core_x(core_x), .core_rho(core_rho), .busy(busy), .state_o(state_o),
    .issue_cnt(issue_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural exp core: Q16.16 in and out, LAT cycles after core_x changes.
  function automatic logic signed [31:0] exp_q16(input logic signed [31:0] x);
    real r;
    r = $exp($itor(x) / 65536.0) * 65536.0;
    return $rtoi(r);
  endfunction

  logic signed [DW-1:0] core_pipe [0:LAT-1];
  always @(posedge sys_clk) begin
    core_pipe[0] <= exp_q16(core_x);
    for (int k = 1; k < LAT; k++) core_pipe[k] <= core_pipe[k-1];
  end
  assign core_rho = core_pipe[LAT-1];

  // Fixed operand per port with hand-computed Q16.16 exp (truncated).
  logic [31:0] op_tab  [NREQ] = '{32'h0000_8000, 32'hFFFF_0000, 32'h0001_0000, 32'h0000_4000};
  logic [31:0] exp_tab [NREQ] = '{32'h0001_A612, 32'h0000_5E2D, 32'h0002_B7E1, 32'h0001_48B5};

  typedef struct { logic [NREQ-1:0] oh; logic [31:0] data; int cyc; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rsp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Issue side: every handshake pushes the response the requester must receive.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      chk("ready_legal", {bus.req_ready & ~bus.req_valid, 1'b0, $countones(bus.req_ready) > 1}, '0);
      for (int i = 0; i < NREQ; i++)
        if (bus.req_valid[i] && bus.req_ready[i])
          sb.push_back('{NREQ'(1 << i), exp_tab[i], cyc});
    end
  end

  // Result side: pop and compare whenever a strobe shows up.
  always @(negedge sys_clk) begin
    if (bus.rsp_valid != '0) begin
      exp_t e;
      rsp_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_rsp", bus.rsp_valid, '0);
      end else begin
        e = sb.pop_front();
        chk("rsp_valid", bus.rsp_valid, e.oh);
        chk("rsp_data", bus.rsp_data, e.data);
        chk("rsp_latency", cyc - e.cyc, LAT + 2);
      end
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_grant(input logic [NREQ-1:0] want, input string name);
    int n;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (bus.req_ready == '0 && n < 40);
    chk(name, bus.req_ready, want);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge sys_clk);
      n++;
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] g1 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [NREQ-1:0] g3 [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
    logic [NREQ-1:0] g4 [5] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    int base, hs;
    logic saw_drain;

    bus.req_data  = {op_tab[3], op_tab[2], op_tab[1], op_tab[0]};
    bus.req_valid = 4'hF;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_state", state_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_issue_cnt", issue_cnt, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_core_x", core_x, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);

    // Warm-up holds off all grants, then round robin from port 0
    step();
    sys_rst = 1'b0;
    for (int i = 0; i < WARM; i++) begin
      @(negedge sys_clk);
      chk("warm_no_ready", bus.req_ready, 0);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      chk("t1_grant", bus.req_ready, g1[i]);
    end
    chk("t1_state_run", state_o, 1);
    step();
    bus.req_valid = '0;
    wait_empty();

    // Single operand 1.0 on port 2
    step();
    bus.req_valid = 4'b0100;
    wait_grant(4'b0100, "t2_grant");
    step();
    bus.req_valid = '0;
    wait_empty();

    // Port 1 alone leaves rr_ptr at 2, then ports 1 and 3 alternate from 3
    step();
    bus.req_valid = 4'b0010;
    wait_grant(4'b0010, "t3_first");
    step();
    bus.req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      chk("t3_alt_grant", bus.req_ready, g3[i]);
    end
    step();
    bus.req_valid = '0;
    wait_empty();

    // Five in flight, then disable: drain to HALT with no grants
    step();
    bus.req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      chk("t4_grant", bus.req_ready, g4[i]);
    end
    step();
    cfg_enable = 1'b0;
    base = rsp_cnt;
    saw_drain = 1'b0;
    @(negedge sys_clk);
    chk("t4_disable_ready", bus.req_ready, 0);
    chk("t4_disable_state", state_o, 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      chk("t4_drain_ready", bus.req_ready, 0);
      if (state_o == 2'd2) saw_drain = 1'b1;
      if (state_o == 2'd3) break;
    end
    chk("t4_saw_drain", saw_drain, 1);
    chk("t4_halt", state_o, 3);
    chk("t4_busy", busy, 0);
    chk("t4_strobes", rsp_cnt - base, 5);
    chk("t4_issue_cnt", issue_cnt, 16);
    step();
    cfg_enable = 1'b1;
    bus.req_valid = '0;
    @(negedge sys_clk);
    chk("t4_still_halt", state_o, 3);
    @(negedge sys_clk);
    chk("t4_rerun", state_o, 1);

    // Six in flight, then reset: nothing returns, warm-up restarts
    step();
    bus.req_valid = 4'hF;
    hs = 0;
    for (int i = 0; i < 20 && hs < 6; i++) begin
      @(negedge sys_clk);
      if (bus.req_ready != '0) hs++;
    end
    chk("t5_handshakes", hs, 6);
    step();
    sys_rst = 1'b1;
    bus.req_valid = '0;
    @(negedge sys_clk);
    chk("t5_pre_busy", busy, 1);
    chk("t5_pre_issue_cnt", issue_cnt, 22);
    @(posedge sys_clk);
    sb.delete();
    base = rsp_cnt;
    #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("t5_busy", busy, 0);
    chk("t5_issue_cnt", issue_cnt, 0);
    chk("t5_state_warm", state_o, 0);
    for (int i = 1; i < WARM; i++) begin
      @(negedge sys_clk);
      chk("t5_warm", state_o, 0);
    end
    @(negedge sys_clk);
    chk("t5_run", state_o, 1);
    repeat (10) @(negedge sys_clk);
    chk("t5_no_strobe", rsp_cnt - base, 0);

    // issue_cnt wraps from all-ones to zero
    step();
    force dut.issue_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.issue_cnt_q;
    @(negedge sys_clk);
    chk("t6_preload", issue_cnt, 32'hFFFF_FFFF);
    step();
    bus.req_valid = 4'b0001;
    wait_grant(4'b0001, "t6_grant");
    step();
    bus.req_valid = '0;
    @(negedge sys_clk);
    chk("t6_wrap", issue_cnt, 0);
    wait_empty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
